// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle between a FIFO producer/consumer and sync_fifo_ext.
// The master side drives requests; the slave side is the FIFO itself.
interface sync_fifo_ext_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

   logic                  write_en;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  full;
   logic                  almost_full;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   level;
   logic                  overflow;
   logic                  underflow;
   logic                  err_clr;

   modport master (
      output write_en, write_data, read_en, err_clr,
      input  read_data, full, almost_full, empty, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  write_en, write_data, read_en, err_clr,
      output read_data, full, almost_full, empty, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with level count, registered status flags, sticky error flags
// and a choice of registered (FWFT=0) or first-word-fall-through (FWFT=1) read.
module sync_fifo_ext #(
   parameter int DATA_WIDTH        = 8,
   parameter int FIFO_DEPTH        = 16,
   parameter int FIFO_ALMOST_FULL  = FIFO_DEPTH - 1,
   parameter int FIFO_ALMOST_EMPTY = 1,
   parameter int FWFT              = 0
) (
   input logic             clk,
   input logic             rst_n,
   sync_fifo_ext_if.slave  bus
);
   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(FIFO_ALMOST_FULL);
   localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(FIFO_ALMOST_EMPTY);
   localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

   if (FIFO_DEPTH < 4 || (1 << ADDR_WIDTH) != FIFO_DEPTH) begin : g_bad_depth
      $error("sync_fifo_ext: FIFO_DEPTH=%0d must be a power of two >= 4", FIFO_DEPTH);
   end
   if (FIFO_ALMOST_FULL < 1 || FIFO_ALMOST_FULL > FIFO_DEPTH) begin : g_bad_af
      $error("sync_fifo_ext: FIFO_ALMOST_FULL=%0d outside 1..FIFO_DEPTH", FIFO_ALMOST_FULL);
   end
   if (FIFO_ALMOST_EMPTY < 0 || FIFO_ALMOST_EMPTY > FIFO_DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_ext: FIFO_ALMOST_EMPTY=%0d outside 0..FIFO_DEPTH-1", FIFO_ALMOST_EMPTY);
   end

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  full_q, empty_q, afull_q, aempty_q;
   logic                  overflow_q, underflow_q;
   logic                  write_valid, read_valid;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Acceptance uses registered flags only, so a full FIFO rejects the write
   // and an empty FIFO rejects the read even when both requests arrive together.
   assign write_valid = bus.write_en & ~full_q;
   assign read_valid  = bus.read_en  & ~empty_q;
   assign rd_addr     = rd_ptr_q[ADDR_WIDTH-1:0];

   always_comb begin
      level_d = level_q;
      case ({write_valid, read_valid})
         2'b10:   level_d = level_q + PTR_ONE;
         2'b01:   level_d = level_q - PTR_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= (FIFO_ALMOST_FULL == 0);
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (write_valid) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (read_valid)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         level_q     <= level_d;
         full_q      <= (level_d == DEPTH_LVL);
         empty_q     <= (level_d == '0);
         afull_q     <= (level_d >= AF_LVL);
         aempty_q    <= (level_d <= AE_LVL);
         // A new error event wins over a clear in the same cycle.
         overflow_q  <= (bus.write_en & full_q)  | (overflow_q  & ~bus.err_clr);
         underflow_q <= (bus.read_en  & empty_q) | (underflow_q & ~bus.err_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (write_valid) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.write_data;
   end

   if (FWFT != 0) begin : g_fwft
      assign bus.read_data = mem_q[rd_addr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)          rdata_q <= '0;
         else if (read_valid) rdata_q <= mem_q[rd_addr];
      end
      assign bus.read_data = rdata_q;
   end

   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.level        = level_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: a registered-read instance and a FWFT instance
// share one clock and reset; expected values are hand-derived constants.
module tb_sync_fifo_ext;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sync_fifo_ext_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) ifa ();
   sync_fifo_ext_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) ifb ();

   sync_fifo_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   sync_fifo_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifa.write_en = 1'b0; ifa.write_data = 8'h00; ifa.read_en = 1'b0; ifa.err_clr = 1'b0;
      ifb.write_en = 1'b0; ifb.write_data = 8'h00; ifb.read_en = 1'b0; ifb.err_clr = 1'b0;

      // Asynchronous reset, observed with no clock edge in between
      #1 rst_n = 1'b0;
      #1;
      chk("rst_empty",     32'(ifa.empty),        1);
      chk("rst_aempty",    32'(ifa.almost_empty), 1);
      chk("rst_full",      32'(ifa.full),         0);
      chk("rst_afull",     32'(ifa.almost_full),  0);
      chk("rst_level",     32'(ifa.level),        0);
      chk("rst_overflow",  32'(ifa.overflow),     0);
      chk("rst_underflow", 32'(ifa.underflow),    0);
      chk("rst_rdata",     32'(ifa.read_data),    0);
      chk("rst_b_empty",   32'(ifb.empty),        1);
      chk("rst_b_level",   32'(ifb.level),        0);
      #10 rst_n = 1'b1;
      step();
      chk("idle_empty", 32'(ifa.empty), 1);

      // Fill to full with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         ifa.write_en = 1'b1; ifa.write_data = 8'(i);
         step();
         chk("fill_level",  32'(ifa.level),        32'(i));
         chk("fill_full",   32'(ifa.full),         32'(i == 16));
         chk("fill_afull",  32'(ifa.almost_full),  32'(i >= 15));
         chk("fill_aempty", 32'(ifa.almost_empty), 32'(i <= 1));
         chk("fill_empty",  32'(ifa.empty),        0);
      end
      ifa.write_en = 1'b0;

      // Write into a full FIFO is dropped and flags overflow
      ifa.write_en = 1'b1; ifa.write_data = 8'hEE;
      step();
      ifa.write_en = 1'b0;
      chk("ovf_level", 32'(ifa.level),     16);
      chk("ovf_flag",  32'(ifa.overflow),  1);
      chk("ovf_full",  32'(ifa.full),      1);
      chk("ovf_rdata", 32'(ifa.read_data), 0);
      step();
      chk("ovf_sticky", 32'(ifa.overflow), 1);
      ifa.err_clr = 1'b1;
      step();
      ifa.err_clr = 1'b0;
      chk("ovf_clr", 32'(ifa.overflow), 0);

      // Full with both requests: read wins, write rejected
      ifa.write_en = 1'b1; ifa.write_data = 8'hEE; ifa.read_en = 1'b1;
      step();
      ifa.write_en = 1'b0;
      chk("fboth_level", 32'(ifa.level),     15);
      chk("fboth_ovf",   32'(ifa.overflow),  1);
      chk("fboth_rdata", 32'(ifa.read_data), 8'h01);
      for (int i = 2; i <= 16; i++) begin
         step();
         chk("drain_rdata", 32'(ifa.read_data), 32'(i));
      end
      ifa.read_en = 1'b0;
      chk("drain_empty", 32'(ifa.empty), 1);
      chk("drain_level", 32'(ifa.level), 0);

      // Underflow set has priority over a simultaneous clear
      ifa.err_clr = 1'b1; ifa.read_en = 1'b1;
      step();
      chk("unf_prio",  32'(ifa.underflow), 1);
      chk("unf_ovclr", 32'(ifa.overflow),  0);
      chk("unf_rdata", 32'(ifa.read_data), 8'h10);
      chk("unf_level", 32'(ifa.level),     0);
      ifa.read_en = 1'b0;
      step();
      ifa.err_clr = 1'b0;
      chk("unf_clr", 32'(ifa.underflow), 0);
      ifa.read_en = 1'b1;
      step();
      chk("unf_set",    32'(ifa.underflow), 1);
      chk("unf_rdata2", 32'(ifa.read_data), 8'h10);

      // Empty with both requests: write wins, read rejected
      ifa.write_en = 1'b1; ifa.write_data = 8'hA5;
      step();
      ifa.write_en = 1'b0;
      chk("eboth_level", 32'(ifa.level),     1);
      chk("eboth_unf",   32'(ifa.underflow), 1);
      chk("eboth_empty", 32'(ifa.empty),     0);
      chk("eboth_rdata", 32'(ifa.read_data), 8'h10);
      step();
      chk("eboth_pop",   32'(ifa.read_data), 8'hA5);
      chk("eboth_empty2", 32'(ifa.empty),    1);
      ifa.read_en = 1'b0; ifa.err_clr = 1'b1;
      step();
      ifa.err_clr = 1'b0;
      chk("eboth_clr", 32'(ifa.underflow), 0);

      // Pointer wrap at constant level 3
      for (int k = 0; k < 3; k++) begin
         ifa.write_en = 1'b1; ifa.write_data = 8'(8'h20 + k);
         step();
      end
      for (int k = 0; k < 40; k++) begin
         ifa.write_en = 1'b1; ifa.write_data = 8'(8'h23 + k); ifa.read_en = 1'b1;
         step();
         chk("wrap_rdata", 32'(ifa.read_data), 32'(8'h20 + k));
         chk("wrap_level", 32'(ifa.level),     3);
      end
      ifa.write_en = 1'b0;
      for (int k = 40; k < 43; k++) begin
         step();
         chk("wrap_tail", 32'(ifa.read_data), 32'(8'h20 + k));
      end
      ifa.read_en = 1'b0;
      chk("wrap_empty", 32'(ifa.empty), 1);

      // First-word-fall-through instance
      ifb.write_en = 1'b1; ifb.write_data = 8'h3C;
      step();
      ifb.write_en = 1'b0;
      chk("fwft_empty", 32'(ifb.empty),     0);
      chk("fwft_rdata", 32'(ifb.read_data), 8'h3C);
      chk("fwft_level", 32'(ifb.level),     1);
      step();
      chk("fwft_hold", 32'(ifb.read_data), 8'h3C);
      ifb.read_en = 1'b1;
      step();
      ifb.read_en = 1'b0;
      chk("fwft_pop_empty", 32'(ifb.empty), 1);
      chk("fwft_pop_level", 32'(ifb.level), 0);
      ifb.write_en = 1'b1; ifb.write_data = 8'h5A; ifb.read_en = 1'b1;
      step();
      ifb.write_en = 1'b0;
      chk("fwft_eboth_unf",   32'(ifb.underflow), 1);
      chk("fwft_eboth_empty", 32'(ifb.empty),     0);
      chk("fwft_eboth_rdata", 32'(ifb.read_data), 8'h5A);
      step();
      ifb.read_en = 1'b0;
      chk("fwft_eboth_pop", 32'(ifb.empty), 1);

      // Reset in the middle of operation at level 9
      for (int i = 0; i < 9; i++) begin
         ifa.write_en = 1'b1; ifa.write_data = 8'(8'h40 + i);
         step();
      end
      ifa.write_en = 1'b0;
      chk("mid_level9", 32'(ifa.level), 9);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_empty",  32'(ifa.empty),     1);
      chk("mid_level",  32'(ifa.level),     0);
      chk("mid_rdata",  32'(ifa.read_data), 0);
      chk("mid_b_unf",  32'(ifb.underflow), 0);
      #2 rst_n = 1'b1;
      ifa.write_en = 1'b1; ifa.write_data = 8'h77;
      step();
      ifa.write_en = 1'b0; ifa.read_en = 1'b1;
      step();
      ifa.read_en = 1'b0;
      chk("post_rst_rdata", 32'(ifa.read_data), 8'h77);
      chk("post_rst_empty", 32'(ifa.empty),     1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
